// File: rtl/dcache_pkg.sv
// Shared types and default widths for the direct-mapped data cache.
package dcache_pkg;

   typedef enum logic [1:0] {
      IDLE,
      READ_MISS,
      WRITE_THRU
   } dcache_state_t;

   localparam int DC_ADDR_BITS  = 16;
   localparam int DC_DATA_BITS  = 16;
   localparam int DC_INDEX_BITS = 4;

endpackage

// File: rtl/dmem_cache_if.sv
// Cache port bundle: pipeline request/response plus the backing-memory handshake.
interface dmem_cache_if import dcache_pkg::*; #(
   parameter int ADDR_BITS = DC_ADDR_BITS,
   parameter int DATA_BITS = DC_DATA_BITS
);

   logic                 cache_en_i;
   logic                 write_read_i;
   logic [ADDR_BITS-1:0] addr_i;
   logic [DATA_BITS-1:0] data_i;
   logic [DATA_BITS-1:0] data_o;
   logic                 stall_o;
   logic                 mem_req_o;
   logic                 mem_we_o;
   logic [ADDR_BITS-1:0] mem_addr_o;
   logic [DATA_BITS-1:0] mem_wdata_o;
   logic                 mem_ack_i;
   logic [DATA_BITS-1:0] mem_rdata_i;

   // Pipeline stage and backing memory together drive the requester side.
   modport master (
      output cache_en_i, write_read_i, addr_i, data_i, mem_ack_i, mem_rdata_i,
      input  data_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
   );

   // The cache is the responder to the pipeline and the requester to memory.
   modport slave (
      input  cache_en_i, write_read_i, addr_i, data_i, mem_ack_i, mem_rdata_i,
      output data_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
   );

endinterface

// File: rtl/dcache_array.sv
// Tag/data/valid storage: one combinational read port, one synchronous write port.
module dcache_array import dcache_pkg::*; #(
   parameter int INDEX_BITS = DC_INDEX_BITS,
   parameter int TAG_BITS   = DC_ADDR_BITS - DC_INDEX_BITS,
   parameter int DATA_BITS  = DC_DATA_BITS
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [INDEX_BITS-1:0] rd_index,
   output logic                  rd_valid,
   output logic [TAG_BITS-1:0]   rd_tag,
   output logic [DATA_BITS-1:0]  rd_data,
   input  logic                  wr_en,
   input  logic [INDEX_BITS-1:0] wr_index,
   input  logic [TAG_BITS-1:0]   wr_tag,
   input  logic [DATA_BITS-1:0]  wr_data
);

   localparam int LINES = 1 << INDEX_BITS;

   logic [LINES-1:0]     valid_q;
   logic [TAG_BITS-1:0]  tag_q  [LINES];
   logic [DATA_BITS-1:0] data_q [LINES];

   // Valid bits are the only state cleared by reset; any write marks the line valid.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= '0;
      end else if (wr_en) begin
         valid_q[wr_index] <= 1'b1;
      end
   end

   // Tag and data storage is never reset, valid bits guard it.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         tag_q[wr_index]  <= wr_tag;
         data_q[wr_index] <= wr_data;
      end
   end

   assign rd_valid = valid_q[rd_index];
   assign rd_tag   = tag_q[rd_index];
   assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/dmem_cache.sv
// Direct-mapped write-through data cache: hit compare, miss/write FSM and memory registers.
module dmem_cache import dcache_pkg::*; #(
   parameter int ADDR_BITS  = DC_ADDR_BITS,
   parameter int DATA_BITS  = DC_DATA_BITS,
   parameter int INDEX_BITS = DC_INDEX_BITS
) (
   input logic         clk_i,
   input logic         rst_i,
   dmem_cache_if.slave bus
);

   localparam int TAG_BITS = ADDR_BITS - INDEX_BITS;

   dcache_state_t        state_q, state_d;
   logic                 mem_req_q, mem_req_d;
   logic                 mem_we_q, mem_we_d;
   logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_BITS-1:0] mem_wdata_q, mem_wdata_d;
   logic                 done_q, done_d;

   logic [INDEX_BITS-1:0] index;
   logic [TAG_BITS-1:0]   tag;
   logic                  rd_valid;
   logic [TAG_BITS-1:0]   rd_tag;
   logic [DATA_BITS-1:0]  rd_data;
   logic                  hit, load_req, store_req, replay;
   logic                  arr_we;
   logic [INDEX_BITS-1:0] arr_index;
   logic [TAG_BITS-1:0]   arr_tag;
   logic [DATA_BITS-1:0]  arr_data;
   logic                  stall;
   logic [DATA_BITS-1:0]  data_out;

   assign index     = bus.addr_i[INDEX_BITS-1:0];
   assign tag       = bus.addr_i[ADDR_BITS-1:INDEX_BITS];
   assign hit       = rd_valid && (rd_tag == tag);
   assign load_req  = bus.cache_en_i && !bus.write_read_i;
   assign store_req = bus.cache_en_i && bus.write_read_i;
   // A store still held right after its own write-through completed must not re-issue.
   assign replay    = done_q && store_req && (bus.addr_i == mem_addr_q)
                      && (bus.data_i == mem_wdata_q);

   dcache_array #(
      .INDEX_BITS (INDEX_BITS),
      .TAG_BITS   (TAG_BITS),
      .DATA_BITS  (DATA_BITS)
   ) u_array (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .rd_index (index),
      .rd_valid (rd_valid),
      .rd_tag   (rd_tag),
      .rd_data  (rd_data),
      .wr_en    (arr_we),
      .wr_index (arr_index),
      .wr_tag   (arr_tag),
      .wr_data  (arr_data)
   );

   // Next-state, memory-register next values, array write and pipeline outputs.
   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      done_d      = 1'b0;
      stall       = 1'b0;
      data_out    = '0;
      arr_we      = 1'b0;
      arr_index   = index;
      arr_tag     = tag;
      arr_data    = bus.data_i;
      case (state_q)
         IDLE: begin
            if (load_req) begin
               if (hit) begin
                  data_out = rd_data;
               end else begin
                  stall      = 1'b1;
                  state_d    = READ_MISS;
                  mem_req_d  = 1'b1;
                  mem_we_d   = 1'b0;
                  mem_addr_d = bus.addr_i;
               end
            end else if (store_req && !replay) begin
               stall       = 1'b1;
               arr_we      = hit;
               state_d     = WRITE_THRU;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b1;
               mem_addr_d  = bus.addr_i;
               mem_wdata_d = bus.data_i;
            end
         end
         READ_MISS: begin
            stall = 1'b1;
            if (bus.mem_ack_i) begin
               arr_we    = 1'b1;
               arr_index = mem_addr_q[INDEX_BITS-1:0];
               arr_tag   = mem_addr_q[ADDR_BITS-1:INDEX_BITS];
               arr_data  = bus.mem_rdata_i;
               mem_req_d = 1'b0;
               state_d   = IDLE;
            end
         end
         WRITE_THRU: begin
            stall = 1'b1;
            if (bus.mem_ack_i) begin
               mem_req_d = 1'b0;
               done_d    = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (rst_i) begin
         stall    = 1'b0;
         data_out = '0;
         arr_we   = 1'b0;
      end
   end

   // State and backing-memory registers, synchronously reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         done_q      <= done_d;
      end
   end

   assign bus.stall_o     = stall;
   assign bus.data_o      = data_out;
   assign bus.mem_req_o   = mem_req_q;
   assign bus.mem_we_o    = mem_we_q;
   assign bus.mem_addr_o  = mem_addr_q;
   assign bus.mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_dmem_cache.sv
// Directed self-checking bench for dmem_cache; the bench plays pipeline and backing memory.
module tb_dmem_cache;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   dmem_cache_if #(.ADDR_BITS(16), .DATA_BITS(16)) bus ();

   dmem_cache #(
      .ADDR_BITS  (16),
      .DATA_BITS  (16),
      .INDEX_BITS (4)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   // Counts one comparison and reports it if the observed value differs.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", tag, actual, expected);
      end
   endtask

   // Drives one cycle of inputs just after a falling edge, then lets combinational outputs settle.
   task automatic applyStimulus(input logic r, input logic en, input logic wr,
                                input logic [15:0] addr, input logic [15:0] data,
                                input logic ack, input logic [15:0] rdata);
      @(negedge clk);
      rst              = r;
      bus.cache_en_i   = en;
      bus.write_read_i = wr;
      bus.addr_i       = addr;
      bus.data_i       = data;
      bus.mem_ack_i    = ack;
      bus.mem_rdata_i  = rdata;
      #1;
   endtask

   // Directed sequence; each step names the cycle it represents.
   initial begin
      bus.cache_en_i   = 1'b0;
      bus.write_read_i = 1'b0;
      bus.addr_i       = '0;
      bus.data_i       = '0;
      bus.mem_ack_i    = 1'b0;
      bus.mem_rdata_i  = '0;

      // Reset held with a load pending: outputs forced quiet.
      applyStimulus(1, 1, 0, 16'h0012, 16'h0, 0, 16'h0);
      checkOutput("rst_stall", bus.stall_o, 0);
      checkOutput("rst_data", bus.data_o, 0);
      checkOutput("rst_req", bus.mem_req_o, 0);
      checkOutput("rst_we", bus.mem_we_o, 0);
      checkOutput("rst_addr", bus.mem_addr_o, 0);
      checkOutput("rst_wdata", bus.mem_wdata_o, 0);

      // Cold load miss at 0x0012, ack three cycles after request rises.
      applyStimulus(0, 1, 0, 16'h0012, 16'h0, 0, 16'h0);
      checkOutput("miss_issue_stall", bus.stall_o, 1);
      checkOutput("miss_issue_req", bus.mem_req_o, 0);
      applyStimulus(0, 1, 0, 16'h0012, 16'h0, 0, 16'h0);
      checkOutput("miss_req", bus.mem_req_o, 1);
      checkOutput("miss_we", bus.mem_we_o, 0);
      checkOutput("miss_addr", bus.mem_addr_o, 16'h0012);
      checkOutput("miss_stall1", bus.stall_o, 1);
      applyStimulus(0, 1, 0, 16'h0012, 16'h0, 0, 16'h0);
      checkOutput("miss_stall2", bus.stall_o, 1);
      applyStimulus(0, 1, 0, 16'h0012, 16'h0, 0, 16'h0);
      checkOutput("miss_stall3", bus.stall_o, 1);
      checkOutput("miss_req_held", bus.mem_req_o, 1);
      applyStimulus(0, 1, 0, 16'h0012, 16'h0, 1, 16'hBEEF);
      checkOutput("miss_ack_stall", bus.stall_o, 1);
      applyStimulus(0, 1, 0, 16'h0012, 16'h0, 0, 16'h0);
      checkOutput("refill_stall", bus.stall_o, 0);
      checkOutput("refill_data", bus.data_o, 16'hBEEF);
      checkOutput("refill_req", bus.mem_req_o, 0);

      // No request: idle outputs.
      applyStimulus(0, 0, 0, 16'h0012, 16'h0, 0, 16'h0);
      checkOutput("idle_stall", bus.stall_o, 0);
      checkOutput("idle_data", bus.data_o, 0);

      // Repeat load hits in the same cycle and issues nothing.
      applyStimulus(0, 1, 0, 16'h0012, 16'h0, 0, 16'h0);
      checkOutput("hit_stall", bus.stall_o, 0);
      checkOutput("hit_data", bus.data_o, 16'hBEEF);
      applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
      checkOutput("hit_no_req", bus.mem_req_o, 0);

      // Store hit 0x1234 to 0x0012; held store after ack is accepted without re-issue.
      applyStimulus(0, 1, 1, 16'h0012, 16'h1234, 0, 16'h0);
      checkOutput("st_hit_stall", bus.stall_o, 1);
      applyStimulus(0, 1, 1, 16'h0012, 16'h1234, 0, 16'h0);
      checkOutput("st_hit_req", bus.mem_req_o, 1);
      checkOutput("st_hit_we", bus.mem_we_o, 1);
      checkOutput("st_hit_addr", bus.mem_addr_o, 16'h0012);
      checkOutput("st_hit_wdata", bus.mem_wdata_o, 16'h1234);
      applyStimulus(0, 1, 1, 16'h0012, 16'h1234, 1, 16'h0);
      checkOutput("st_ack_stall", bus.stall_o, 1);
      applyStimulus(0, 1, 1, 16'h0012, 16'h1234, 0, 16'h0);
      checkOutput("st_replay_stall", bus.stall_o, 0);
      checkOutput("st_replay_req", bus.mem_req_o, 0);
      applyStimulus(0, 1, 0, 16'h0012, 16'h0, 0, 16'h0);
      checkOutput("st_after_stall", bus.stall_o, 0);
      checkOutput("st_after_data", bus.data_o, 16'h1234);
      checkOutput("st_replay_no_req", bus.mem_req_o, 0);

      // Store miss to 0x0035: write-through only, no allocate.
      applyStimulus(0, 1, 1, 16'h0035, 16'hAAAA, 0, 16'h0);
      checkOutput("st_miss_stall", bus.stall_o, 1);
      applyStimulus(0, 1, 1, 16'h0035, 16'hAAAA, 0, 16'h0);
      checkOutput("st_miss_req", bus.mem_req_o, 1);
      checkOutput("st_miss_we", bus.mem_we_o, 1);
      checkOutput("st_miss_addr", bus.mem_addr_o, 16'h0035);
      checkOutput("st_miss_wdata", bus.mem_wdata_o, 16'hAAAA);
      applyStimulus(0, 1, 1, 16'h0035, 16'hAAAA, 1, 16'h0);
      applyStimulus(0, 1, 0, 16'h0035, 16'h0, 0, 16'h0);
      checkOutput("no_alloc_stall", bus.stall_o, 1);
      applyStimulus(0, 1, 0, 16'h0035, 16'h0, 0, 16'h0);
      checkOutput("no_alloc_req", bus.mem_req_o, 1);
      checkOutput("no_alloc_we", bus.mem_we_o, 0);
      checkOutput("no_alloc_addr", bus.mem_addr_o, 16'h0035);
      applyStimulus(0, 1, 0, 16'h0035, 16'h0, 1, 16'h5555);
      applyStimulus(0, 1, 0, 16'h0035, 16'h0, 0, 16'h0);
      checkOutput("no_alloc_data", bus.data_o, 16'h5555);
      checkOutput("no_alloc_done", bus.stall_o, 0);

      // Conflict on index 2: 0x0102 evicts 0x0012.
      applyStimulus(0, 1, 0, 16'h0102, 16'h0, 0, 16'h0);
      checkOutput("conf_stall", bus.stall_o, 1);
      applyStimulus(0, 1, 0, 16'h0102, 16'h0, 0, 16'h0);
      checkOutput("conf_addr", bus.mem_addr_o, 16'h0102);
      applyStimulus(0, 1, 0, 16'h0102, 16'h0, 1, 16'h7777);
      applyStimulus(0, 1, 0, 16'h0102, 16'h0, 0, 16'h0);
      checkOutput("conf_data", bus.data_o, 16'h7777);
      applyStimulus(0, 1, 0, 16'h0012, 16'h0, 0, 16'h0);
      checkOutput("evicted_stall", bus.stall_o, 1);
      applyStimulus(0, 1, 0, 16'h0012, 16'h0, 0, 16'h0);
      checkOutput("evicted_addr", bus.mem_addr_o, 16'h0012);
      applyStimulus(0, 1, 0, 16'h0012, 16'h0, 1, 16'h1234);
      applyStimulus(0, 1, 0, 16'h0012, 16'h0, 0, 16'h0);
      checkOutput("evicted_data", bus.data_o, 16'h1234);

      // Reset in second READ_MISS cycle, then a stray ack.
      applyStimulus(0, 1, 0, 16'h0044, 16'h0, 0, 16'h0);
      checkOutput("rm_rst_issue", bus.stall_o, 1);
      applyStimulus(0, 1, 0, 16'h0044, 16'h0, 0, 16'h0);
      checkOutput("rm_rst_req1", bus.mem_req_o, 1);
      applyStimulus(1, 1, 0, 16'h0044, 16'h0, 0, 16'h0);
      checkOutput("rm_rst_stall", bus.stall_o, 0);
      checkOutput("rm_rst_data", bus.data_o, 0);
      applyStimulus(0, 0, 0, 16'h0044, 16'h0, 1, 16'h9999);
      checkOutput("rm_rst_req_drop", bus.mem_req_o, 0);
      checkOutput("stray_ack_stall", bus.stall_o, 0);
      applyStimulus(0, 0, 0, 16'h0044, 16'h0, 0, 16'h0);
      checkOutput("stray_ack_req", bus.mem_req_o, 0);
      applyStimulus(0, 1, 0, 16'h0044, 16'h0, 0, 16'h0);
      checkOutput("reload_stall", bus.stall_o, 1);
      checkOutput("reload_data", bus.data_o, 0);
      applyStimulus(0, 1, 0, 16'h0044, 16'h0, 0, 16'h0);
      checkOutput("reload_req", bus.mem_req_o, 1);
      checkOutput("reload_addr", bus.mem_addr_o, 16'h0044);
      applyStimulus(0, 1, 0, 16'h0044, 16'h0, 1, 16'h4444);
      applyStimulus(0, 1, 0, 16'h0012, 16'h0, 0, 16'h0);
      checkOutput("rst_cleared_valid", bus.stall_o, 1);
      applyStimulus(0, 1, 0, 16'h0012, 16'h0, 0, 16'h0);
      checkOutput("rst_refill_addr", bus.mem_addr_o, 16'h0012);
      applyStimulus(0, 1, 0, 16'h0012, 16'h0, 1, 16'hCAFE);
      applyStimulus(0, 1, 0, 16'h0012, 16'h0, 0, 16'h0);
      checkOutput("rst_refill_data", bus.data_o, 16'hCAFE);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
